// File: rtl/hazard_ctrl_gen.sv
// hazard_ctrl_gen: pipeline stall/flush control for load-use, redirects and multi-cycle mul/div, with saturating perf counters
module hazard_ctrl_gen #(
  parameter int REG_ADDR_W = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] d_srcA,
  input  logic [REG_ADDR_W-1:0] d_srcB,
  input  logic                  d_useA,
  input  logic                  d_useB,
  input  logic [REG_ADDR_W-1:0] E_dstM,
  input  logic                  E_is_load,
  input  logic                  E_muldiv,
  input  logic                  E_redirect,
  input  logic                  cnt_clr,
  output logic                  F_stall,
  output logic                  D_stall,
  output logic                  D_bubble,
  output logic                  E_stall,
  output logic                  E_bubble,
  output logic                  M_bubble,
  output logic                  muldiv_busy,
  output logic                  muldiv_done,
  output logic [CNT_W-1:0]      cyc_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam int CW = MULDIV_LAT > 1 ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CW-1:0] INIT = CW'(MULDIV_LAT > 1 ? MULDIV_LAT - 2 : 0);
  localparam bit LAT1 = MULDIV_LAT == 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic lu, start, md_hold, hold, redir, lu_stall;
  always_comb begin
    lu = E_is_load && E_dstM != '0 &&
         ((d_useA && d_srcA == E_dstM) || (d_useB && d_srcB == E_dstM));
    start = state == IDLE && E_muldiv && !LAT1;
    md_hold = start || (state == BUSY && cnt != '0);
    state_n = start ? BUSY : (state == BUSY && cnt == '0) ? IDLE : state;
    cnt_n = start ? INIT : (state == BUSY && cnt != '0) ? cnt - CW'(1) : cnt;
    hold = !rst && md_hold;
    redir = !rst && !md_hold && E_redirect;
    lu_stall = !rst && !md_hold && !E_redirect && lu;
    F_stall = hold || lu_stall;
    D_stall = hold || lu_stall;
    D_bubble = redir;
    E_stall = hold;
    E_bubble = redir || lu_stall;
    M_bubble = hold;
    muldiv_busy = state == BUSY;
    muldiv_done = !rst && ((state == BUSY && cnt == '0) || (state == IDLE && E_muldiv && LAT1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
    if (rst || cnt_clr) begin
      cyc_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CNT_W'(cyc_cnt != '1);
      stall_cnt <= stall_cnt + CNT_W'(F_stall && stall_cnt != '1);
      flush_cnt <= flush_cnt + CNT_W'(redir && flush_cnt != '1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// tb_hazard_ctrl_gen: directed vector and sequence checks of hazard_ctrl_gen at LAT=4/CNT_W=32 and LAT=1/CNT_W=3
module tb_hazard_ctrl_gen;
  logic clk = 0, rst = 1;
  logic [4:0] d_srcA, d_srcB, E_dstM;
  logic d_useA, d_useB, E_is_load, E_muldiv, E_redirect, cnt_clr;
  logic a_fs, a_ds, a_db, a_es, a_eb, a_mb, a_busy, a_done;
  logic b_fs, b_ds, b_db, b_es, b_eb, b_mb, b_busy, b_done;
  logic [31:0] a_cyc, a_stall, a_flush;
  logic [2:0] b_cyc, b_stall, b_flush;
  logic [5:0] a_ctl, b_ctl;
  int total = 0, bad = 0, exp_cyc = 0, es = 0, ef = 0;
  logic [31:0] s0;
  typedef struct {
    int sa, sb, ua, ub, dm, ld, rd;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[10];
  always #5 clk = ~clk;
  assign a_ctl = {a_fs, a_ds, a_db, a_es, a_eb, a_mb};
  assign b_ctl = {b_fs, b_ds, b_db, b_es, b_eb, b_mb};
  hazard_ctrl_gen #(.REG_ADDR_W(5), .MULDIV_LAT(4), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .d_srcA(d_srcA), .d_srcB(d_srcB), .d_useA(d_useA), .d_useB(d_useB),
    .E_dstM(E_dstM), .E_is_load(E_is_load), .E_muldiv(E_muldiv), .E_redirect(E_redirect),
    .cnt_clr(cnt_clr), .F_stall(a_fs), .D_stall(a_ds), .D_bubble(a_db), .E_stall(a_es),
    .E_bubble(a_eb), .M_bubble(a_mb), .muldiv_busy(a_busy), .muldiv_done(a_done),
    .cyc_cnt(a_cyc), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );
  hazard_ctrl_gen #(.REG_ADDR_W(5), .MULDIV_LAT(1), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .d_srcA(d_srcA), .d_srcB(d_srcB), .d_useA(d_useA), .d_useB(d_useB),
    .E_dstM(E_dstM), .E_is_load(E_is_load), .E_muldiv(E_muldiv), .E_redirect(E_redirect),
    .cnt_clr(cnt_clr), .F_stall(b_fs), .D_stall(b_ds), .D_bubble(b_db), .E_stall(b_es),
    .E_bubble(b_eb), .M_bubble(b_mb), .muldiv_busy(b_busy), .muldiv_done(b_done),
    .cyc_cnt(b_cyc), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );
  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    exp_cyc = (rst || cnt_clr) ? 0 : exp_cyc + 1;
    #1;
  endtask
  task automatic idle();
    d_srcA = 0; d_srcB = 0; d_useA = 0; d_useB = 0; E_dstM = 0;
    E_is_load = 0; E_muldiv = 0; E_redirect = 0; cnt_clr = 0;
  endtask
  task automatic load_use();
    E_is_load = 1; E_dstM = 8; d_srcB = 8; d_useB = 1; d_srcA = 3; d_useA = 1;
  endtask
  initial begin
    vecs[0] = '{3, 8, 1, 1, 8, 1, 0, 6'b110010};
    vecs[1] = '{3, 8, 1, 1, 0, 1, 0, 6'b000000};
    vecs[2] = '{3, 8, 1, 0, 8, 1, 0, 6'b000000};
    vecs[3] = '{8, 2, 1, 0, 8, 1, 0, 6'b110010};
    vecs[4] = '{8, 2, 0, 1, 8, 1, 0, 6'b000000};
    vecs[5] = '{8, 8, 1, 1, 8, 0, 0, 6'b000000};
    vecs[6] = '{3, 8, 1, 1, 8, 1, 1, 6'b001010};
    vecs[7] = '{0, 0, 0, 0, 0, 0, 1, 6'b001010};
    vecs[8] = '{31, 0, 1, 0, 31, 1, 0, 6'b110010};
    vecs[9] = '{0, 0, 1, 1, 0, 1, 0, 6'b000000};
    idle();
    rst = 1;
    load_use();
    step();
    step();
    chk("rst_ctl_a", a_ctl, 0);
    chk("rst_ctl_b", b_ctl, 0);
    E_muldiv = 1;
    #1;
    chk("rst_done", {a_done, b_done}, 0);
    rst = 0;
    idle();
    #1;
    chk("init_cyc", a_cyc, 0);
    chk("init_stall", a_stall, 0);
    chk("init_flush", a_flush, 0);
    chk("init_busy", a_busy, 0);
    for (int i = 0; i < 10; i++) begin
      d_srcA = 5'(vecs[i].sa); d_srcB = 5'(vecs[i].sb);
      d_useA = vecs[i].ua[0]; d_useB = vecs[i].ub[0]; E_dstM = 5'(vecs[i].dm);
      E_is_load = vecs[i].ld[0]; E_redirect = vecs[i].rd[0];
      #1;
      chk($sformatf("vec%0d_ctl", i), a_ctl, vecs[i].exp);
      es += int'(vecs[i].exp[5]);
      ef += int'(vecs[i].exp[3]);
      step();
    end
    idle();
    #1;
    chk("tbl_stall_cnt", a_stall, es);
    chk("tbl_flush_cnt", a_flush, ef);
    chk("tbl_cyc_cnt", a_cyc, exp_cyc);
    s0 = a_stall;
    E_muldiv = 1;
    #1;
    chk("md_t0_ctl", a_ctl, 6'b110101);
    chk("md_t0_busy", a_busy, 0);
    chk("md_t0_done", a_done, 0);
    chk("lat1_done", b_done, 1);
    chk("lat1_ctl", b_ctl, 0);
    chk("lat1_busy", b_busy, 0);
    step();
    load_use();
    E_redirect = 1;
    #1;
    chk("md_t1_ctl", a_ctl, 6'b110101);
    chk("md_t1_busy", a_busy, 1);
    chk("md_t1_done", a_done, 0);
    chk("lat1_t1_busy", b_busy, 0);
    step();
    idle();
    E_muldiv = 1;
    #1;
    chk("md_t2_ctl", a_ctl, 6'b110101);
    chk("md_t2_done", a_done, 0);
    step();
    chk("md_t3_ctl", a_ctl, 0);
    chk("md_t3_done", a_done, 1);
    chk("md_t3_busy", a_busy, 1);
    step();
    E_muldiv = 0;
    #1;
    chk("md_t4_busy", a_busy, 0);
    chk("md_t4_done", a_done, 0);
    chk("md_stall_cnt", a_stall, s0 + 3);
    chk("md_flush_cnt", a_flush, ef);
    E_muldiv = 1;
    step();
    rst = 1;
    E_muldiv = 0;
    #1;
    chk("abort_rst_ctl", a_ctl, 0);
    chk("abort_rst_done", a_done, 0);
    step();
    rst = 0;
    #1;
    chk("abort_busy", a_busy, 0);
    chk("abort_ctl", a_ctl, 0);
    chk("abort_cyc", a_cyc, 0);
    chk("abort_stall", a_stall, 0);
    chk("abort_flush", a_flush, 0);
    step();
    chk("abort_t3_done", a_done, 0);
    chk("abort_t3_busy", a_busy, 0);
    load_use();
    repeat (10) step();
    idle();
    #1;
    chk("sat_stall_b", b_stall, 7);
    chk("sat_cyc_b", b_cyc, 7);
    chk("sat_stall_a", a_stall, 10);
    chk("sat_cyc_a", a_cyc, exp_cyc);
    E_redirect = 1;
    step();
    E_redirect = 0;
    #1;
    chk("flush_one", a_flush, 1);
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    #1;
    chk("clr_cyc_a", a_cyc, 0);
    chk("clr_stall_a", a_stall, 0);
    chk("clr_flush_a", a_flush, 0);
    chk("clr_cyc_b", b_cyc, 0);
    chk("clr_stall_b", b_stall, 0);
    step();
    chk("resume_cyc_a", a_cyc, 1);
    chk("resume_cyc_b", b_cyc, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
